// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode bundle for the instruction fetch queue: fetch/CTRL inputs
// on one side, the decode-facing registers and the occupancy flags on the other.
interface inst_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   if_pc;
  logic [31:0]   if_inst;
  logic          if_ce;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic          id_valid;
  logic          fq_full;
  logic [CW-1:0] fq_count;

  modport master (
    output if_pc, if_inst, if_ce, stall, flush,
    input  id_pc, id_inst, id_valid, fq_full, fq_count
  );

  modport slave (
    input  if_pc, if_inst, if_ce, stall, flush,
    output id_pc, id_inst, id_valid, fq_full, fq_count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular queue between IF and ID. When the queue is empty and decode can
// accept, a fetched word bypasses storage so decode still sees one-cycle latency.
module inst_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_fetch_queue_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic [31:0]   id_pc_q, id_pc_d;
  logic [31:0]   id_inst_q, id_inst_d;
  logic          id_valid_q, id_valid_d;

  logic push, advance, pop, bypass, write_en;

  // Only stall[2] (decode stopped) matters to this stage.
  logic unused_stall;
  assign unused_stall = &{1'b0, bus.stall[5:3], bus.stall[1:0]};

  always_comb begin
    push     = bus.if_ce && !full_q && !bus.flush;
    advance  = !bus.stall[2] && !bus.flush;
    pop      = advance && (count_q != '0);
    bypass   = advance && (count_q == '0) && push;
    write_en = push && !bypass;

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;

    if (pop) begin
      id_pc_d    = pc_mem[rd_ptr_q];
      id_inst_d  = inst_mem[rd_ptr_q];
      id_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
    end else if (bypass) begin
      id_pc_d    = bus.if_pc;
      id_inst_d  = bus.if_inst;
      id_valid_d = 1'b1;
    end else if (advance) begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end

    if (write_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    case ({write_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Flush wins over stall and push; the word fetched this cycle is lost.
    if (bus.flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end

    full_d = (count_d == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Storage has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && write_en) begin
      pc_mem[wr_ptr_q]   <= bus.if_pc;
      inst_mem[wr_ptr_q] <= bus.if_inst;
    end
  end

  assign bus.id_pc    = id_pc_q;
  assign bus.id_inst  = id_inst_q;
  assign bus.id_valid = id_valid_q;
  assign bus.fq_full  = full_q;
  assign bus.fq_count = count_q;
endmodule
